// File: rtl/gbe100_tx_pkg.sv
// Shared types and constants for the 100G transmit framer and its FIFO.
package gbe100_tx_pkg;

  localparam int DATA_W = 512;

  // One buffered beat: payload plus its framing and destination sideband.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              eof;
    logic [31:0]       ip;
    logic [15:0]       port;
  } tx_word_t;

  // Writer state: RUN accepts words, DISCARD throws away the rest of a
  // packet that has already lost a word.
  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } wr_state_t;

  // A zero length would never produce an eof, so it is treated as one word.
  function automatic logic [15:0] eff_len(input logic [15:0] len);
    return (len == 16'd0) ? 16'd1 : len;
  endfunction

endpackage

// File: rtl/gbe100_tx_fifo.sv
// Synchronous first-word-fall-through FIFO of tx_word_t beats.
// The head entry is read combinationally so a word is visible the cycle
// after it is written.
module gbe100_tx_fifo
  import gbe100_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  tx_word_t               wr_word,
  input  logic                   rd_en,
  output tx_word_t               rd_word,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  tx_word_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_wr;
  logic            do_rd;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_word = mem[rd_ptr];

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_word;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gbe100_tx_framer.sv
// Frames user payload into packets for the 100G core: tags eof from a
// per-packet word count, latches the destination on the first word, and
// truncates a packet (discarding its tail) when the buffering overflows.
module gbe100_tx_framer
  import gbe100_tx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic              user_clk,
  input  logic              axis_reset_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic [15:0]       pkt_len,
  input  logic [31:0]       dest_ip,
  input  logic [15:0]       dest_port,
  output logic              din_afull,
  output logic [DATA_W-1:0] gbe_tx_data,
  output logic [3:0]        gbe_tx_valid,
  output logic              gbe_tx_end_of_frame,
  output logic [31:0]       gbe_tx_dest_ip,
  output logic [15:0]       gbe_tx_dest_port,
  input  logic              gbe_tx_ready,
  output logic              overflow,
  input  logic              overflow_ack,
  output logic [31:0]       pkt_count,
  output logic [31:0]       drop_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wr_state_t       state;
  tx_word_t        hold_reg;
  logic            hold_valid;
  logic [15:0]     word_cnt;
  logic [15:0]     len_reg;
  logic [31:0]     ip_reg;
  logic [15:0]     port_reg;

  tx_word_t        head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;

  logic            first_word;
  logic [15:0]     cur_len;
  logic [31:0]     cur_ip;
  logic [15:0]     cur_port;
  logic            is_last;
  logic            push;
  logic            pop;
  logic            drop_run;
  logic            load;
  logic            discard;

  // Sideband comes straight from the inputs on word 0, from the latches after.
  assign first_word = (word_cnt == 16'd0);
  assign cur_len    = first_word ? eff_len(pkt_len) : len_reg;
  assign cur_ip     = first_word ? dest_ip : ip_reg;
  assign cur_port   = first_word ? dest_port : port_reg;
  assign is_last    = (word_cnt == cur_len - 16'd1);

  assign push     = hold_valid && !fifo_full;
  assign pop      = !fifo_empty && gbe_tx_ready;
  assign drop_run = din_valid && (state == RUN) && hold_valid && fifo_full;
  assign load     = din_valid && (state == RUN) && !drop_run;
  assign discard  = din_valid && (state == DISCARD);

  gbe100_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (user_clk),
    .rst_n   (axis_reset_n),
    .wr_en   (push),
    .wr_word (hold_reg),
    .rd_en   (pop),
    .rd_word (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head fields are forced to zero while nothing is buffered (including reset).
  assign gbe_tx_valid        = {4{!fifo_empty}};
  assign gbe_tx_data         = fifo_empty ? '0 : head.data;
  assign gbe_tx_end_of_frame = !fifo_empty && head.eof;
  assign gbe_tx_dest_ip      = fifo_empty ? '0 : head.ip;
  assign gbe_tx_dest_port    = fifo_empty ? '0 : head.port;
  assign din_afull           = (fifo_count >= CW'(AFULL_LEVEL));

  // Word counter and per-packet latches; every valid word counts, kept or not.
  always_ff @(posedge user_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      word_cnt <= '0;
      len_reg  <= '0;
      ip_reg   <= '0;
      port_reg <= '0;
    end else if (din_valid) begin
      if (first_word) begin
        len_reg  <= eff_len(pkt_len);
        ip_reg   <= dest_ip;
        port_reg <= dest_port;
      end
      word_cnt <= is_last ? 16'd0 : word_cnt + 16'd1;
    end
  end

  // One-entry hold stage; a drop marks the held word as the packet's end.
  always_ff @(posedge user_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      hold_reg   <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (load) begin
        hold_reg   <= '{data: din, eof: is_last, ip: cur_ip, port: cur_port};
        hold_valid <= 1'b1;
      end else if (push) begin
        hold_valid <= 1'b0;
      end
      if (drop_run) hold_reg.eof <= 1'b1;
    end
  end

  // Writer FSM; a drop on the packet's last word has no tail to discard.
  always_ff @(posedge user_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (drop_run && !is_last) state <= DISCARD;
        DISCARD: if (din_valid && is_last) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Sticky overflow flag and statistics counters; a new drop beats an ack.
  always_ff @(posedge user_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      overflow   <= 1'b0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      if (drop_run)          overflow <= 1'b1;
      else if (overflow_ack) overflow <= 1'b0;
      if (drop_run || discard) drop_count <= drop_count + 32'd1;
      if (pop && head.eof)     pkt_count  <= pkt_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_gbe100_tx_framer.sv
// Scoreboard bench for gbe100_tx_framer: stimulus pushes the words the core
// should see, a negedge monitor pops and compares every consumed beat.
module tb_gbe100_tx_framer;

  localparam int DEPTH = 16;

  typedef struct {
    logic [511:0] data;
    logic         eof;
    logic [31:0]  ip;
    logic [15:0]  port;
  } exp_t;

  logic         user_clk = 1'b0;
  logic         axis_reset_n = 1'b0;
  logic [511:0] din = '0;
  logic         din_valid = 1'b0;
  logic [15:0]  pkt_len = '0;
  logic [31:0]  dest_ip = '0;
  logic [15:0]  dest_port = '0;
  logic         din_afull;
  logic [511:0] gbe_tx_data;
  logic [3:0]   gbe_tx_valid;
  logic         gbe_tx_end_of_frame;
  logic [31:0]  gbe_tx_dest_ip;
  logic [15:0]  gbe_tx_dest_port;
  logic         gbe_tx_ready = 1'b0;
  logic         overflow;
  logic         overflow_ack = 1'b0;
  logic [31:0]  pkt_count;
  logic [31:0]  drop_count;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   issued = 0;
  int   consumed = 0;
  int   exp_eofs = 0;
  int   exp_drops = 0;
  int   ready_mode = 0;  // 0 low, 1 high, 2 random

  gbe100_tx_framer dut (
    .user_clk            (user_clk),
    .axis_reset_n        (axis_reset_n),
    .din                 (din),
    .din_valid           (din_valid),
    .pkt_len             (pkt_len),
    .dest_ip             (dest_ip),
    .dest_port           (dest_port),
    .din_afull           (din_afull),
    .gbe_tx_data         (gbe_tx_data),
    .gbe_tx_valid        (gbe_tx_valid),
    .gbe_tx_end_of_frame (gbe_tx_end_of_frame),
    .gbe_tx_dest_ip      (gbe_tx_dest_ip),
    .gbe_tx_dest_port    (gbe_tx_dest_port),
    .gbe_tx_ready        (gbe_tx_ready),
    .overflow            (overflow),
    .overflow_ack        (overflow_ack),
    .pkt_count           (pkt_count),
    .drop_count          (drop_count)
  );

  always #5 user_clk = ~user_clk;

  // Core back-pressure, changed just after each rising edge.
  always @(posedge user_clk) begin
    #1;
    if (ready_mode == 2) gbe_tx_ready = 1'($urandom_range(0, 1));
    else                 gbe_tx_ready = (ready_mode == 1);
  end

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, need %0h", nm, act, req);
    end
  endtask

  // Monitor: compares every handshaken beat and checks stability under stall.
  logic         stall_prev = 1'b0;
  logic [611:0] stall_snap = '0;
  int           pop_idx = 0;
  always @(negedge user_clk) begin
    logic [611:0] cur;
    exp_t e;
    cur = {gbe_tx_valid, gbe_tx_data, gbe_tx_end_of_frame, gbe_tx_dest_ip, gbe_tx_dest_port};
    if (!axis_reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (cur !== stall_snap) begin
          errors++;
          $display("FAIL stall_hold: outputs changed while not ready (eof %0b ip %h, need eof %0b ip %h)",
                   gbe_tx_end_of_frame, gbe_tx_dest_ip, stall_snap[48], stall_snap[47:16]);
        end
      end
      stall_prev = gbe_tx_valid[0] && !gbe_tx_ready;
      stall_snap = cur;
      if (gbe_tx_valid[0] && gbe_tx_ready) begin
        consumed++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word: unexpected beat eof=%0b ip=%h, need none", gbe_tx_end_of_frame, gbe_tx_dest_ip);
        end else begin
          e = exp_q.pop_front();
          if (gbe_tx_valid !== 4'hf || gbe_tx_data !== e.data || gbe_tx_end_of_frame !== e.eof ||
              gbe_tx_dest_ip !== e.ip || gbe_tx_dest_port !== e.port) begin
            errors++;
            $display("FAIL word%0d: got v=%h eof=%0b ip=%h port=%h data=%h need v=f eof=%0b ip=%h port=%h data=%h",
                     pop_idx, gbe_tx_valid, gbe_tx_end_of_frame, gbe_tx_dest_ip, gbe_tx_dest_port,
                     gbe_tx_data, e.eof, e.ip, e.port, e.data);
          end else begin
            $display("pop %0d: eof=%0b ip=%h port=%h", pop_idx, e.eof, e.ip, e.port);
          end
        end
        pop_idx++;
      end
    end
  end

  // Present one input beat for one clock.
  task automatic drive(input logic v, input logic [511:0] d, input logic [15:0] len,
                       input logic [31:0] ip, input logic [15:0] port);
    din_valid = v;
    din       = d;
    pkt_len   = len;
    dest_ip   = ip;
    dest_port = port;
    @(posedge user_clk);
    #1;
  endtask

  task automatic expect_word(input logic [511:0] d, input logic eof, input logic [31:0] ip,
                             input logic [15:0] port);
    exp_t e;
    e.data = d; e.eof = eof; e.ip = ip; e.port = port;
    exp_q.push_back(e);
    if (eof) exp_eofs++;
  endtask

  // Send one packet whose outstanding words never exceed the buffering, so
  // nothing is dropped: every word arrives, eof on word L-1, word-0 sideband.
  task automatic send_pkt(input int len_field, input bit vary, input int gap_pct, input bit lat_chk);
    int L;
    int wait_n;
    logic [31:0]  ip0;
    logic [15:0]  port0;
    logic [511:0] d;
    L     = (len_field == 0) ? 1 : len_field;
    ip0   = $urandom;
    port0 = 16'($urandom);
    for (int i = 0; i < L; i++) begin
      wait_n = 0;
      while ((issued - consumed > 12 || $urandom_range(0, 99) < gap_pct) && wait_n < 2000) begin
        drive(1'b0, rand512(), 16'($urandom), $urandom, 16'($urandom));
        wait_n++;
      end
      if (wait_n >= 2000) chk("throttle_timeout", 64'(issued - consumed), 64'd12);
      d = rand512();
      expect_word(d, (i == L - 1), ip0, port0);
      issued++;
      if (i == 0) drive(1'b1, d, 16'(len_field), ip0, port0);
      else if (vary) drive(1'b1, d, 16'($urandom), $urandom, 16'($urandom));
      else drive(1'b1, d, 16'(len_field), ip0, port0);
      if (lat_chk && i == 0) chk("latency_cycle1_valid", 64'(gbe_tx_valid), 64'h0);
      if (lat_chk && i == 1) chk("latency_cycle2_valid", 64'(gbe_tx_valid), 64'hf);
    end
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge user_clk);
      #1;
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge user_clk);
    #1;
    chk("idle_valid", 64'(gbe_tx_valid), 64'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_k;
    logic [31:0] ipx;
    logic [15:0] portx;
    logic [511:0] d;

    // Reset state.
    repeat (3) @(posedge user_clk);
    #1;
    axis_reset_n = 1'b1;
    @(posedge user_clk);
    #1;
    chk("rst_valid", 64'(gbe_tx_valid), 64'h0);
    chk("rst_afull", 64'(din_afull), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    chk("rst_pkt_count", 64'(pkt_count), 64'h0);
    chk("rst_drop_count", 64'(drop_count), 64'h0);

    // Two 4-word packets back to back, core always ready.
    ready_mode = 1;
    repeat (2) @(posedge user_clk);
    #1;
    send_pkt(4, 1'b0, 0, 1'b1);
    send_pkt(4, 1'b1, 0, 1'b0);
    drain();
    chk("pkt_count_two", 64'(pkt_count), 64'd2);

    // Zero length means single-word packets.
    for (int i = 0; i < 3; i++) send_pkt(0, 1'b1, 0, 1'b0);
    drain();
    chk("pkt_count_len0", 64'(pkt_count), 64'(exp_eofs));

    // Random lengths, gaps, changing sideband and back-pressure.
    ready_mode = 2;
    for (int p = 0; p < 40; p++) send_pkt($urandom_range(0, 9), 1'b1, 25, 1'b0);
    drain();
    chk("pkt_count_rand", 64'(pkt_count), 64'(exp_eofs));
    chk("drop_count_rand", 64'(drop_count), 64'd0);

    // Overflow: 64-word packet into a stalled core; hold + FIFO keep 17 words.
    ready_mode = 0;
    repeat (2) @(posedge user_clk);
    #1;
    ipx = $urandom;
    portx = 16'($urandom);
    first_k = -1;
    for (int k = 0; k < 64; k++) begin
      d = rand512();
      if (k < DEPTH + 1) expect_word(d, (k == DEPTH), ipx, portx);
      overflow_ack = (k == DEPTH + 1);
      drive(1'b1, d, 16'd64, ipx, portx);
      if (first_k < 0 && din_afull) first_k = k;
      if (k == DEPTH + 1) chk("overflow_set_beats_ack", 64'(overflow), 64'd1);
    end
    overflow_ack = 1'b0;
    din_valid = 1'b0;
    exp_drops = 64 - (DEPTH + 1);
    chk("afull_first_occupancy", 64'(first_k), 64'd12);
    chk("afull_when_full", 64'(din_afull), 64'd1);
    chk("drop_count_ovf", 64'(drop_count), 64'(exp_drops));
    chk("overflow_sticky", 64'(overflow), 64'd1);
    ready_mode = 1;
    drain();
    chk("pkt_count_ovf", 64'(pkt_count), 64'(exp_eofs));
    overflow_ack = 1'b1;
    @(posedge user_clk);
    #1;
    overflow_ack = 1'b0;
    chk("overflow_cleared", 64'(overflow), 64'd0);
    issued = consumed;
    send_pkt(6, 1'b1, 0, 1'b0);
    drain();
    chk("pkt_after_ovf", 64'(pkt_count), 64'(exp_eofs));

    // Reset in the middle of an 8-word packet.
    ipx = $urandom;
    for (int k = 0; k < 3; k++) begin
      d = rand512();
      expect_word(d, 1'b0, ipx, 16'h1234);
      drive(1'b1, d, 16'd8, ipx, 16'h1234);
    end
    din_valid = 1'b0;
    axis_reset_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(gbe_tx_valid), 64'h0);
    chk("mrst_data_zero", 64'(gbe_tx_data != '0), 64'h0);
    chk("mrst_eof", 64'(gbe_tx_end_of_frame), 64'h0);
    chk("mrst_ip", 64'(gbe_tx_dest_ip), 64'h0);
    chk("mrst_port", 64'(gbe_tx_dest_port), 64'h0);
    chk("mrst_pkt_count", 64'(pkt_count), 64'h0);
    chk("mrst_drop_count", 64'(drop_count), 64'h0);
    chk("mrst_afull", 64'(din_afull), 64'h0);
    exp_q.delete();
    exp_eofs = 0;
    exp_drops = 0;
    issued = consumed;
    repeat (2) @(posedge user_clk);
    #1;
    axis_reset_n = 1'b1;
    @(posedge user_clk);
    #1;
    send_pkt(5, 1'b1, 0, 1'b0);
    drain();
    chk("pkt_count_post_rst", 64'(pkt_count), 64'd1);
    chk("drop_count_post_rst", 64'(drop_count), 64'(exp_drops));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gbe100_tx_framer.md
GBE100_TX_FRAMER -- requirements
Module: gbe100_tx_framer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, words of buffering between the framer and the 100G core (power of two, at least 4).
REQ-002 SHALL have parameter AFULL_LEVEL, default 12, the FIFO occupancy at or above which din_afull asserts.
REQ-003 SHALL have port user_clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port axis_reset_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port din, input, 512, user payload word.
REQ-006 SHALL have port din_valid, input, 1, which qualifies din.
REQ-007 SHALL have port pkt_len, input, 16, packet length in words, sampled on the first word of each packet.
REQ-008 SHALL have ports dest_ip (input, 32) and dest_port (input, 16), both sampled on the first word of each packet.
REQ-009 SHALL have port din_afull, output, 1, asserted when FIFO occupancy >= AFULL_LEVEL.
REQ-010 SHALL have port gbe_tx_data, output, 512, the FIFO head word.
REQ-011 SHALL have port gbe_tx_valid, output, 4; all four bits are equal and assert when the FIFO is not empty.
REQ-012 SHALL have port gbe_tx_end_of_frame, output, 1, the eof flag of the FIFO head.
REQ-013 SHALL have ports gbe_tx_dest_ip (output, 32) and gbe_tx_dest_port (output, 16), the destination of the FIFO head.
REQ-014 SHALL have port gbe_tx_ready, input, 1, the core's tready; the FIFO head is consumed when gbe_tx_valid[0] and gbe_tx_ready are both high.
REQ-015 SHALL have ports overflow (output, 1, sticky) and overflow_ack (input, 1).
REQ-016 SHALL have ports pkt_count (output, 32, eof words consumed) and drop_count (output, 32, input words discarded).

Function
REQ-017 SHALL keep a 16-bit word counter; a pkt_len of 0 is treated as 1; the eof flag is set on the word where counter == latched_len-1, and the counter then wraps to 0.
REQ-018 SHALL load an accepted word into a one-entry hold register (data, eof, ip, port); hold pushes into the FIFO in any cycle it is valid and the FIFO is not full, and a new word may load in the same cycle.
REQ-019 SHALL, in state RUN, drop a din_valid word when hold is valid and cannot push; on the drop it forces hold.eof=1, increments drop_count, sets overflow and enters DISCARD.
REQ-020 SHALL, in state DISCARD, keep counting but discard and count every word, and return to RUN after the counted last word of the packet (that word is discarded too).
REQ-021 SHALL, on a drop that lands on a packet's counted last word, stay in RUN.
REQ-022 SHALL provide a FIFO that is first-word-fall-through: a din word entering an idle, empty path appears on gbe_tx_* two cycles later.
REQ-023 SHALL, with gbe_tx_ready held high and no overflow, sustain one word per cycle.
REQ-024 SHALL increment pkt_count on consumption of an eof word; pkt_count and drop_count wrap modulo 2^32.
REQ-025 SHALL clear overflow on overflow_ack; a simultaneous set wins.
REQ-026 SHALL hold all gbe_tx_* outputs stable while valid and not ready.

Reset
REQ-027 SHALL, while axis_reset_n is low, asynchronously clear the FIFO, hold, counter, both counts and overflow, and put the writer in RUN.
REQ-028 SHALL drive all outputs to 0 during reset.
REQ-029 SHALL, on a reset asserted mid-packet, discard the partial packet, so the first post-reset word starts a new packet.

Structure
REQ-030 SHALL take the width constant (512), the word struct (data, eof, ip, port) and the state enum {RUN, DISCARD} from package gbe100_tx_pkg.
REQ-031 SHALL implement the FIFO as sub-module gbe100_tx_fifo: synchronous, FWFT, with count output.

Verification
REQ-032 SHALL cover: pkt_len=4, 8 consecutive words, ready=1 -> two packets, eof on words 3 and 7, first valid 2 cycles after first din, pkt_count=2.
REQ-033 SHALL cover: dest_ip changed mid-packet -> the whole packet carries the value sampled on word 0.
REQ-034 SHALL cover: ready=0, pkt_len=64, continuous din -> din_afull at occupancy 12, drop at 18th word, FIFO's last written word + hold eof=1, drop_count=47, overflow=1, next packet intact.
REQ-035 SHALL cover: pkt_len=0 -> every word has eof=1.
REQ-036 SHALL cover: overflow_ack asserted in the same cycle as a new drop -> overflow stays 1.
REQ-037 SHALL cover: axis_reset_n pulsed low mid-packet -> outputs 0 immediately, next packet counts from word 0.
